// File: rtl/ctrl_pkg.sv
// Shared control-word type and encodings for the pipelined controller.
// Holds opcode constants, ALU codes, mux-select encodings and the muldiv FSM state type.
package ctrl_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        logic       Branch;
        logic [1:0] Jump;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrc_a;
        logic       ALUSrc_b;
        logic [3:0] ALU_Control;
        logic [2:0] Funct3;
        logic       MulDiv;
        logic       Illegal;
    } ctrl_t;

    typedef enum logic {StIdle, StBusy} md_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_MD  = 2'b11;

    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam int unsigned CNT_W = $clog2(64) + 1;

    // alt selects sub/sra; caller decides when funct7[5] is meaningful
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: instruction fields to control word and immediate select.
// Illegal encodings yield an all-zero word with only Illegal set.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [6:0] OP_D,
    input  logic [2:0] Funct3_D,
    input  logic [6:0] Funct7_D,
    output ctrl_t      ctrl,
    output logic [2:0] ImmSrc_D,
    output logic       Illegal_D
);

    logic illegal;

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        ImmSrc_D = IMM_I;
        illegal  = 1'b0;
        unique case (OP_D)
            OP_RTYPE: begin
                ctrl.RegWrite = 1'b1;
                if (Funct7_D == F7_MULDIV) begin
                    illegal        = !ENABLE_M;
                    ctrl.ResultSrc = RES_MD;
                    ctrl.MulDiv    = 1'b1;
                end else begin
                    ctrl.ALU_Control = alu_op(Funct3_D, Funct7_D[5]);
                end
            end
            OP_ITYPE: begin
                ctrl.RegWrite    = 1'b1;
                ctrl.ALUSrc_b    = 1'b1;
                // addi has no subtract form; funct7[5] only marks srai
                ctrl.ALU_Control = alu_op(Funct3_D, Funct7_D[5] && (Funct3_D == 3'b101));
            end
            OP_LOAD: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.ResultSrc = RES_MEM;
                ctrl.ALUSrc_b  = 1'b1;
            end
            OP_STORE: begin
                ctrl.MemWrite = 1'b1;
                ctrl.ALUSrc_b = 1'b1;
                ImmSrc_D      = IMM_S;
            end
            OP_BRANCH: begin
                illegal          = (Funct3_D[2:1] == 2'b01);
                ctrl.Branch      = 1'b1;
                ctrl.ALU_Control = !Funct3_D[2] ? ALU_SUB : (Funct3_D[1] ? ALU_SLTU : ALU_SLT);
                ImmSrc_D         = IMM_B;
            end
            OP_JAL: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.Jump      = JUMP_JAL;
                ctrl.ResultSrc = RES_PC4;
                ImmSrc_D       = IMM_J;
            end
            OP_JALR: begin
                ctrl.RegWrite  = 1'b1;
                ctrl.Jump      = JUMP_JALR;
                ctrl.ResultSrc = RES_PC4;
                ctrl.ALUSrc_b  = 1'b1;
            end
            OP_LUI: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrc_a = SRCA_ZERO;
                ctrl.ALUSrc_b = 1'b1;
                ImmSrc_D      = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUSrc_a = SRCA_PC;
                ctrl.ALUSrc_b = 1'b1;
                ImmSrc_D      = IMM_U;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.Illegal = 1'b1;
            ImmSrc_D     = IMM_I;
        end else begin
            ctrl.Funct3 = Funct3_D;
        end
    end

    assign Illegal_D = illegal;

endmodule

// File: rtl/pipe_controller.sv
// Pipelined controller: E/M/W control registers, E-stage branch/jump resolution and
// the muldiv occupancy FSM that holds E for multi-cycle RV32M operations.
module pipe_controller
    import ctrl_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] OP_D,
    input  logic [2:0] Funct3_D,
    input  logic [6:0] Funct7_D,
    input  logic       FlushE,
    input  logic       Zero_E,
    input  logic       LT_E,
    output logic [2:0] ImmSrc_D,
    output logic       Illegal_D,
    output ctrl_t      Ctrl_E,
    output logic [1:0] PCSrc_E,
    output logic       MD_Busy,
    output logic       MD_Done,
    output logic       RegWrite_M,
    output logic       MemWrite_M,
    output logic [1:0] ResultSrc_M,
    output logic [2:0] Funct3_M,
    output logic       RegWrite_W,
    output logic [1:0] ResultSrc_W
);

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);

    ctrl_t            ctrl_d;
    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] lat_d;
    logic [CNT_W-1:0] lat_e;
    logic             md_hold;
    logic             taken;

    ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .OP_D      (OP_D),
        .Funct3_D  (Funct3_D),
        .Funct7_D  (Funct7_D),
        .ctrl      (ctrl_d),
        .ImmSrc_D  (ImmSrc_D),
        .Illegal_D (Illegal_D)
    );

    assign lat_d   = ctrl_d.Funct3[2] ? DIV_LAT : MUL_LAT;
    assign lat_e   = Ctrl_E.Funct3[2] ? DIV_LAT : MUL_LAT;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign md_hold = (state_q == StBusy) && MD_Busy;

    // cnt_q is the 1-based E-residency cycle of the current op; the final cycle is cnt_q == LAT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ctrl_E  <= CTRL_BUBBLE;
            state_q <= StIdle;
            cnt_q   <= '0;
            MD_Busy <= 1'b0;
            MD_Done <= 1'b0;
        end else if (FlushE) begin
            Ctrl_E  <= CTRL_BUBBLE;
            state_q <= StIdle;
            cnt_q   <= '0;
            MD_Busy <= 1'b0;
            MD_Done <= 1'b0;
        end else if (md_hold) begin
            cnt_q   <= cnt_inc;
            MD_Busy <= (cnt_inc < lat_e);
            MD_Done <= (cnt_inc == lat_e);
        end else begin
            Ctrl_E <= ctrl_d;
            if (ctrl_d.MulDiv && (lat_d > CNT_W'(1))) begin
                state_q <= StBusy;
                cnt_q   <= CNT_W'(1);
                MD_Busy <= 1'b1;
                MD_Done <= 1'b0;
            end else begin
                state_q <= StIdle;
                cnt_q   <= '0;
                MD_Busy <= 1'b0;
                MD_Done <= ctrl_d.MulDiv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_M  <= 1'b0;
            MemWrite_M  <= 1'b0;
            ResultSrc_M <= RES_ALU;
            Funct3_M    <= 3'b000;
            RegWrite_W  <= 1'b0;
            ResultSrc_W <= RES_ALU;
        end else begin
            if (MD_Busy) begin
                RegWrite_M  <= 1'b0;
                MemWrite_M  <= 1'b0;
                ResultSrc_M <= RES_ALU;
                Funct3_M    <= 3'b000;
            end else begin
                RegWrite_M  <= Ctrl_E.RegWrite;
                MemWrite_M  <= Ctrl_E.MemWrite;
                ResultSrc_M <= Ctrl_E.ResultSrc;
                Funct3_M    <= Ctrl_E.Funct3;
            end
            RegWrite_W  <= RegWrite_M;
            ResultSrc_W <= ResultSrc_M;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (Ctrl_E.Funct3)
            3'b000:         taken = Zero_E;
            3'b001:         taken = !Zero_E;
            3'b100, 3'b110: taken = LT_E;
            3'b101, 3'b111: taken = !LT_E;
            default:        taken = 1'b0;
        endcase

        PCSrc_E = PC_PLUS4;
        if (Ctrl_E.Branch) begin
            if (taken) PCSrc_E = PC_IMM;
        end else if (Ctrl_E.Jump == JUMP_JAL) begin
            PCSrc_E = PC_IMM;
        end else if (Ctrl_E.Jump == JUMP_JALR) begin
            PCSrc_E = PC_ALU;
        end
    end

endmodule

// File: tb/tb_pipe_controller.sv
// Randomized bench: three differently parameterised controllers checked each cycle
// against a queue-free stage model that tracks remaining E residency per op.
module tb_pipe_controller;

    localparam int N = 3;

    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        logic       Branch;
        logic [1:0] Jump;
        logic [1:0] ResultSrc;
        logic [1:0] ALUSrc_a;
        logic       ALUSrc_b;
        logic [3:0] ALU_Control;
        logic [2:0] Funct3;
        logic       MulDiv;
        logic       Illegal;
    } exp_ctrl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       flush, zero, lt;

    logic [2:0]  imm_src [N];
    logic        ill     [N];
    logic [18:0] ctrl_e  [N];
    logic [1:0]  pcsrc   [N];
    logic        busy    [N];
    logic        done    [N];
    logic        rw_m    [N];
    logic        mw_m    [N];
    logic [1:0]  rs_m    [N];
    logic [2:0]  f3_m    [N];
    logic        rw_w    [N];
    logic [1:0]  rs_w    [N];

    bit          cfg_en  [N] = '{1'b1, 1'b0, 1'b1};
    int unsigned cfg_mul [N] = '{1, 2, 2};
    int unsigned cfg_div [N] = '{33, 33, 4};
    int unsigned alu_by_f3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

    exp_ctrl_t me [N];
    exp_ctrl_t mm [N];
    exp_ctrl_t mw [N];
    int        left [N];
    int        bcnt [N];
    int        dcnt [N];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_controller #(.ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(33)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .OP_D(op), .Funct3_D(f3), .Funct7_D(f7), .FlushE(flush),
        .Zero_E(zero), .LT_E(lt), .ImmSrc_D(imm_src[0]), .Illegal_D(ill[0]), .Ctrl_E(ctrl_e[0]),
        .PCSrc_E(pcsrc[0]), .MD_Busy(busy[0]), .MD_Done(done[0]), .RegWrite_M(rw_m[0]),
        .MemWrite_M(mw_m[0]), .ResultSrc_M(rs_m[0]), .Funct3_M(f3_m[0]), .RegWrite_W(rw_w[0]),
        .ResultSrc_W(rs_w[0])
    );

    pipe_controller #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(33)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .OP_D(op), .Funct3_D(f3), .Funct7_D(f7), .FlushE(flush),
        .Zero_E(zero), .LT_E(lt), .ImmSrc_D(imm_src[1]), .Illegal_D(ill[1]), .Ctrl_E(ctrl_e[1]),
        .PCSrc_E(pcsrc[1]), .MD_Busy(busy[1]), .MD_Done(done[1]), .RegWrite_M(rw_m[1]),
        .MemWrite_M(mw_m[1]), .ResultSrc_M(rs_m[1]), .Funct3_M(f3_m[1]), .RegWrite_W(rw_w[1]),
        .ResultSrc_W(rs_w[1])
    );

    pipe_controller #(.ENABLE_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .OP_D(op), .Funct3_D(f3), .Funct7_D(f7), .FlushE(flush),
        .Zero_E(zero), .LT_E(lt), .ImmSrc_D(imm_src[2]), .Illegal_D(ill[2]), .Ctrl_E(ctrl_e[2]),
        .PCSrc_E(pcsrc[2]), .MD_Busy(busy[2]), .MD_Done(done[2]), .RegWrite_M(rw_m[2]),
        .MemWrite_M(mw_m[2]), .ResultSrc_M(rs_m[2]), .Funct3_M(f3_m[2]), .RegWrite_W(rw_w[2]),
        .ResultSrc_W(rs_w[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_ctrl_t ref_decode(input logic [6:0] o, input logic [2:0] fn3,
                                             input logic [6:0] fn7, input bit en_m);
        exp_ctrl_t   c;
        int unsigned alu;
        c   = '0;
        alu = alu_by_f3[fn3];
        case (o)
            7'b0110011: begin
                c.RegWrite = 1'b1;
                if (fn7 == 7'b0000001) begin
                    c.MulDiv    = 1'b1;
                    c.ResultSrc = 2'b11;
                    alu         = 0;
                    c.Illegal   = !en_m;
                end else if (fn7[5] && fn3 == 3'd0) alu = 1;
                else if (fn7[5] && fn3 == 3'd5) alu = 9;
            end
            7'b0010011: begin
                c.RegWrite = 1'b1;
                c.ALUSrc_b = 1'b1;
                if (fn7[5] && fn3 == 3'd5) alu = 9;
            end
            7'b0000011: begin c.RegWrite = 1'b1; c.ResultSrc = 2'b01; c.ALUSrc_b = 1'b1; alu = 0; end
            7'b0100011: begin c.MemWrite = 1'b1; c.ALUSrc_b = 1'b1; alu = 0; end
            7'b1100011: begin
                c.Branch  = 1'b1;
                alu       = fn3[2] ? (fn3[1] ? 6 : 5) : 1;
                c.Illegal = (fn3 == 3'd2 || fn3 == 3'd3);
            end
            7'b1101111: begin c.RegWrite = 1'b1; c.Jump = 2'b01; c.ResultSrc = 2'b10; alu = 0; end
            7'b1100111: begin
                c.RegWrite = 1'b1; c.Jump = 2'b10; c.ResultSrc = 2'b10; c.ALUSrc_b = 1'b1; alu = 0;
            end
            7'b0110111: begin c.RegWrite = 1'b1; c.ALUSrc_a = 2'b10; c.ALUSrc_b = 1'b1; alu = 0; end
            7'b0010111: begin c.RegWrite = 1'b1; c.ALUSrc_a = 2'b01; c.ALUSrc_b = 1'b1; alu = 0; end
            default: c.Illegal = 1'b1;
        endcase
        if (c.Illegal) begin
            c         = '0;
            c.Illegal = 1'b1;
            return c;
        end
        c.ALU_Control = alu[3:0];
        c.Funct3      = fn3;
        return c;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o, input logic illegal);
        if (illegal) return 3'd0;
        case (o)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111:             return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_pcsrc(input exp_ctrl_t e, input logic z, input logic l);
        bit tk;
        if (!e.Branch) return e.Jump;
        case (e.Funct3)
            3'd0:       tk = z;
            3'd1:       tk = !z;
            3'd4, 3'd6: tk = l;
            3'd5, 3'd7: tk = !l;
            default:    tk = 1'b0;
        endcase
        return tk ? 2'b01 : 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            me[i] = '0; mm[i] = '0; mw[i] = '0; left[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                me[i] = '0; mm[i] = '0; mw[i] = '0; left[i] = 0;
            end else begin
                bit hold = (left[i] > 1);
                mw[i] = mm[i];
                mm[i] = hold ? exp_ctrl_t'(0) : me[i];
                if (flush) begin
                    me[i] = '0; left[i] = 0;
                end else if (hold) begin
                    left[i]--;
                end else begin
                    me[i]   = ref_decode(op, f3, f7, cfg_en[i]);
                    left[i] = !me[i].MulDiv ? 0 : (me[i].Funct3[2] ? cfg_div[i] : cfg_mul[i]);
                end
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            exp_ctrl_t d = ref_decode(op, f3, f7, cfg_en[i]);
            check_eq($sformatf("imm_src[%0d]", i), imm_src[i], ref_imm(op, d.Illegal));
            check_eq($sformatf("illegal_d[%0d]", i), ill[i], d.Illegal);
            check_eq($sformatf("ctrl_e[%0d]", i), ctrl_e[i], me[i]);
            check_eq($sformatf("pcsrc_e[%0d]", i), pcsrc[i], ref_pcsrc(me[i], zero, lt));
            check_eq($sformatf("md_busy[%0d]", i), busy[i], left[i] > 1);
            check_eq($sformatf("md_done[%0d]", i), done[i], me[i].MulDiv && left[i] == 1);
            check_eq($sformatf("m_stage[%0d]", i), {rw_m[i], mw_m[i], rs_m[i], f3_m[i]},
                     {mm[i].RegWrite, mm[i].MemWrite, mm[i].ResultSrc, mm[i].Funct3});
            check_eq($sformatf("w_stage[%0d]", i), {rw_w[i], rs_w[i]},
                     {mw[i].RegWrite, mw[i].ResultSrc});
            bcnt[i] += int'(busy[i]);
            dcnt[i] += int'(done[i]);
        end
    endtask

    task automatic half_b();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic set_d(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
        op = o; f3 = fn3; f7 = fn7;
    endtask

    task automatic nop();
        set_d(7'b0010011, 3'd0, 7'd0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            bcnt[i] = 0; dcnt[i] = 0;
        end
    endtask

    task automatic rand_instr();
        int unsigned k = $urandom_range(0, 15);
        logic [6:0] o;
        logic [6:0] fn7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        logic [2:0] fn3 = 3'($urandom_range(0, 7));
        case (k)
            0, 1, 2: o = 7'b0110011;
            3, 4:    o = 7'b0010011;
            5:       o = 7'b0000011;
            6:       o = 7'b0100011;
            7, 8:    o = 7'b1100011;
            9:       o = 7'b1101111;
            10:      o = 7'b1100111;
            11:      o = 7'b0110111;
            12:      o = 7'b0010111;
            13: begin o = 7'b0110011; fn7 = 7'b0000001; end
            default: begin o = 7'($urandom); fn7 = 7'($urandom); end
        endcase
        set_d(o, fn3, fn7);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; zero = 1'b0; lt = 1'b0;
        model_reset();
        clear_counts();

        // Reset held with an add in D; add must reach E one edge after release
        set_d(7'b0110011, 3'd0, 7'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        nop();
        half_a();
        check_eq("add_in_e", ctrl_e[0], 32'h40000);
        half_b();
        step();
        half_a();
        check_eq("add_in_w", rw_w[0], 1'b1);
        half_b();

        set_d(7'b1100011, 3'b001, 7'd0);
        step();
        nop(); zero = 1'b0;
        half_a();
        check_eq("bne_taken", pcsrc[0], 2'b01);
        half_b();
        set_d(7'b1100011, 3'b101, 7'd0);
        step();
        nop(); lt = 1'b1;
        half_a();
        check_eq("bge_not_taken", pcsrc[0], 2'b00);
        half_b();
        set_d(7'b1100111, 3'b000, 7'd0);
        step();
        nop();
        half_a();
        check_eq("jalr_pcsrc", pcsrc[0], 2'b10);
        half_b();
        set_d(7'b1100011, 3'b010, 7'd0);
        half_a();
        check_eq("branch_f3_010_illegal", ill[0], 1'b1);
        half_b();
        nop();
        half_a();
        check_eq("illegal_word_in_e", ctrl_e[0], 32'h1);
        half_b();

        // Lone div: A stalls 32 cycles, C (DIV=4) 3, B treats it as illegal
        clear_counts();
        set_d(7'b0110011, 3'b100, 7'b0000001);
        step();
        nop();
        repeat (40) step();
        check_eq("div33_busy_len", bcnt[0], 32);
        check_eq("div33_done_len", dcnt[0], 1);
        check_eq("div4_busy_len", bcnt[2], 3);
        check_eq("div4_done_len", dcnt[2], 1);
        check_eq("nom_busy_len", bcnt[1], 0);
        check_eq("nom_done_len", dcnt[1], 0);

        // mul (single cycle on A) immediately followed by div
        clear_counts();
        set_d(7'b0110011, 3'b000, 7'b0000001);
        step();
        set_d(7'b0110011, 3'b101, 7'b0000001);
        step();
        nop();
        repeat (40) step();
        check_eq("mul_div_busy_len", bcnt[0], 32);
        check_eq("mul_div_done_len", dcnt[0], 2);
        check_eq("mul2_busy_len", bcnt[2], 1);

        set_d(7'b0110011, 3'b100, 7'b0000001);
        step();
        nop();
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        half_a();
        check_eq("flush_busy", busy[0], 1'b0);
        check_eq("flush_ctrl_e", ctrl_e[0], 32'h0);
        half_b();

        set_d(7'b0110011, 3'b110, 7'b0000001);
        step();
        nop();
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        half_a();
        check_eq("rst_mid_div_busy", busy[0], 1'b0);
        check_eq("rst_mid_div_ctrl_e", ctrl_e[0], 32'h0);
        half_b();
        rst_n = 1'b1;

        set_d(7'b0110011, 3'b000, 7'b0000001);
        half_a();
        check_eq("nom_mul_illegal", ill[1], 1'b1);
        half_b();
        nop();
        half_a();
        check_eq("nom_mul_ctrl_e", ctrl_e[1], 32'h1);
        check_eq("nom_mul_busy", busy[1], 1'b0);
        half_b();

        for (int c = 0; c < 1500; c++) begin
            rand_instr();
            flush = ($urandom_range(0, 19) == 0);
            zero  = 1'($urandom);
            lt    = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
